field_merge_seq: RTL and testbench
==================================

# field_merge_seq

Sequential, parametrised merge engine that overlays a BLK×BLK falling-block bitmap onto a FIELD_W×FIELD_H playfield bitmap. It scans one block cell per clock and detects collisions and out-of-bounds cells. It either produces a display overlay or commits the block into the background (lock mode). It sits between the game-control FSM, which supplies position, rotated block matrix and background, and the VGA/display path, which consumes `field_display`.

## Interface
- `FIELD_W`, 20: playfield width in cells.
- `FIELD_H`, 20: playfield height in cells.
- `BLK`, 4: block matrix edge length.
- `POS_W`, 5: width of `pos_x`/`pos_y`.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a merge; sampled only in IDLE.
- `mode` input 1: 0 = overlay (display), 1 = lock (commit).
- `pos_x`, `pos_y` input POS_W: field coordinate of block cell (0,0).
- `block_matrix` input BLK*BLK: bit `b_y*BLK+b_x` is the occupancy of block cell (b_x, b_y).
- `field_background` input FIELD_W*FIELD_H: bit `y*FIELD_W+x` is the occupancy of field cell (x, y).
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse when the result is valid.
- `collision` output 1: a set block cell landed on a set background cell.
- `out_of_bounds` output 1: a set block cell fell outside the field.
- `field_display` output FIELD_W*FIELD_H: merged result, held until the next `done`.

## Operation
- States are IDLE, SCAN and DONE.
- IDLE with `start`=1:
  - Latch `mode`, `pos_x`, `pos_y`, `block_matrix` and `field_background` into internal registers.
  - Set the working image to the latched background, clear both flags, set cell counter `c`=0, go to SCAN.
- SCAN, one cell per cycle, c = 0 … BLK*BLK−1, with b_x = c mod BLK and b_y = c / BLK:
  - Compute x = pos_x + b_x and y = pos_y + b_y at POS_W+1 bits. No wrap-around is permitted.
  - If the block bit is 0, do nothing. An empty cell never clears a field bit.
  - If the block bit is 1 and x ≥ FIELD_W or y ≥ FIELD_H: set the sticky `out_of_bounds` flag and skip the write.
  - Otherwise, if the background bit is 1, set the sticky `collision` flag.
  - In both overlay and lock mode, set working bit `y*FIELD_W+x`.
  - At c = BLK*BLK−1, go to DONE.
- DONE:
  - Overlay mode: `field_display` ← working image.
  - Lock mode: `field_display` ← working image only if both flags are 0; otherwise `field_display` ← latched background (the commit is rejected).
  - Pulse `done`, return to IDLE.
- `start` is ignored outside IDLE. Input changes after the start edge have no effect on the operation in flight.
- `collision` and `out_of_bounds` are registered, valid with `done`, and held until the next accepted `start` clears them.
- Index arithmetic uses `$clog2(FIELD_W*FIELD_H)` bits.

## Timing
- Reset value of every output is 0 (`busy`, `done`, `collision`, `out_of_bounds`, `field_display`). State is IDLE.
- `start` is accepted at edge 0.
- `done`=1 and the new `field_display` appear after edge BLK*BLK+1 (17 for BLK=4).
- `busy` is high from after edge 0 through the `done` cycle.
- Back-to-back operation: `start` may be held high. The next operation is accepted at the edge after the `done` cycle, giving a throughput of one merge per BLK*BLK+2 cycles.
- Reset asserted mid-SCAN:
  - Immediate return to IDLE with all outputs 0.
  - No `done` is produced.
  - The operation is not resumed after reset releases.

## Structure
- Package `field_pkg` holds:
  - Defaults for FIELD_W, FIELD_H and BLK.
  - The state enum (IDLE/SCAN/DONE).
  - A function `cell_idx(x, y)` returning `y*FIELD_W+x`.
- Sub-module `field_cell_addr` is combinational. It takes pos, b_x, b_y and produces the field index and an in-bounds flag. Verification reuses it in the scoreboard.
- The FSM, counter, working image and flags live in `field_merge_seq`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0, `busy`=0.
- Overlay: `block_matrix`=16'h0033, pos=(3,5), bg=0, `mode`=0 → `done` after 17 edges. Display bits 103, 104, 123, 124 set, all other bits 0, flags 0.
- Lock collision: same block and pos, bg bit 104 set, `mode`=1 → `collision`=1, `out_of_bounds`=0, `field_display`==bg.
- Edge clip: 16'h0033 at pos=(19,5), `mode`=0 → `out_of_bounds`=1. Only bits 119 and 139 are set; nothing wraps into x=0.
- Wide position: pos_x=31, 16'h0001 → `out_of_bounds`=1, display==bg. This checks that the 6-bit sum prevents wrap.
- Control: pulse `start` at cycle 5 of a busy operation → ignored, exactly one `done`. Assert `rst_n`=0 at cycle 8 of SCAN → outputs 0 and no `done` pulse.

Source files
------------

// File: rtl/field_pkg.sv
// Shared defaults, FSM state type and cell index helper for the playfield merge engine.
package field_pkg;

  localparam int FIELD_W_DEF = 20;
  localparam int FIELD_H_DEF = 20;
  localparam int BLK_DEF     = 4;
  localparam int POS_W_DEF   = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Row-major playfield index. The field width defaults to the package value.
  function automatic int cell_idx(input int x, input int y, input int fw = FIELD_W_DEF);
    return y * fw + x;
  endfunction

endpackage

// File: rtl/field_cell_addr.sv
// Maps one block cell (pos + b_x/b_y) onto a playfield index and an in-bounds flag.
module field_cell_addr
  import field_pkg::*;
#(
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int FIELD_H = FIELD_H_DEF,
  parameter int BLK     = BLK_DEF,
  parameter int POS_W   = POS_W_DEF,
  parameter int BW      = (BLK > 1) ? $clog2(BLK) : 1,
  parameter int IDX_W   = $clog2(FIELD_W * FIELD_H)
) (
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  input  logic [BW-1:0]    b_x,
  input  logic [BW-1:0]    b_y,
  output logic [IDX_W-1:0] idx,
  output logic             in_bounds
);

  // One extra bit so that pos + offset can never wrap back into the field.
  logic [POS_W:0] x;
  logic [POS_W:0] y;

  assign x = {1'b0, pos_x} + (POS_W+1)'(b_x);
  assign y = {1'b0, pos_y} + (POS_W+1)'(b_y);

  assign in_bounds = (int'(x) < FIELD_W) && (int'(y) < FIELD_H);
  assign idx       = IDX_W'(cell_idx(int'(x), int'(y), FIELD_W));

endmodule

// File: rtl/field_merge_seq.sv
// Overlays a BLK x BLK block onto the playfield one cell per clock, flagging
// collisions and out-of-bounds cells; lock mode rejects a commit with any flag set.
module field_merge_seq
  import field_pkg::*;
#(
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int FIELD_H = FIELD_H_DEF,
  parameter int BLK     = BLK_DEF,
  parameter int POS_W   = POS_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       mode,
  input  logic [POS_W-1:0]           pos_x,
  input  logic [POS_W-1:0]           pos_y,
  input  logic [BLK*BLK-1:0]         block_matrix,
  input  logic [FIELD_W*FIELD_H-1:0] field_background,
  output logic                       busy,
  output logic                       done,
  output logic                       collision,
  output logic                       out_of_bounds,
  output logic [FIELD_W*FIELD_H-1:0] field_display
);

  localparam int FN    = FIELD_W * FIELD_H;
  localparam int IDX_W = $clog2(FN);
  localparam int NC    = BLK * BLK;
  localparam int CW    = (NC > 1) ? $clog2(NC) : 1;
  localparam int BW    = (BLK > 1) ? $clog2(BLK) : 1;

  state_t             state;
  logic [CW-1:0]      c;
  logic               mode_q;
  logic [POS_W-1:0]   px_q;
  logic [POS_W-1:0]   py_q;
  logic [NC-1:0]      blk_q;
  logic [FN-1:0]      bg_q;
  logic [FN-1:0]      work;

  logic [BW-1:0]      b_x;
  logic [BW-1:0]      b_y;
  logic [IDX_W-1:0]   idx;
  logic               in_bounds;

  assign b_x = BW'(int'(c) % BLK);
  assign b_y = BW'(int'(c) / BLK);

  field_cell_addr #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H),
    .BLK     (BLK),
    .POS_W   (POS_W)
  ) u_addr (
    .pos_x     (px_q),
    .pos_y     (py_q),
    .b_x       (b_x),
    .b_y       (b_y),
    .idx       (idx),
    .in_bounds (in_bounds)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      c             <= '0;
      mode_q        <= 1'b0;
      px_q          <= '0;
      py_q          <= '0;
      blk_q         <= '0;
      bg_q          <= '0;
      work          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      collision     <= 1'b0;
      out_of_bounds <= 1'b0;
      field_display <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy drops one cycle after done unless the next merge starts straight away
          busy <= start;
          if (start) begin
            mode_q        <= mode;
            px_q          <= pos_x;
            py_q          <= pos_y;
            blk_q         <= block_matrix;
            bg_q          <= field_background;
            work          <= field_background;
            collision     <= 1'b0;
            out_of_bounds <= 1'b0;
            c             <= '0;
            state         <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (blk_q[c]) begin
            if (!in_bounds) begin
              out_of_bounds <= 1'b1;
            end else begin
              if (bg_q[idx]) collision <= 1'b1;
              work[idx] <= 1'b1;
            end
          end
          if (c == CW'(NC - 1)) state <= S_DONE;
          else                  c     <= c + CW'(1);
        end
        S_DONE: begin
          // A rejected lock shows the untouched background
          field_display <= (mode_q && (collision || out_of_bounds)) ? bg_q : work;
          done          <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_field_merge_seq.sv
// Scoreboard bench for field_merge_seq: expected merges are queued at start and checked on done.
module tb_field_merge_seq;
  import field_pkg::*;

  localparam int FW = 20;
  localparam int FH = 20;
  localparam int BL = 4;
  localparam int PW = 5;
  localparam int FN = FW * FH;

  typedef struct packed {
    logic [FN-1:0] disp;
    logic          coll;
    logic          oob;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [PW-1:0] pos_x = '0;
  logic [PW-1:0] pos_y = '0;
  logic [BL*BL-1:0] block_matrix = '0;
  logic [FN-1:0] field_background = '0;
  logic          busy, done, collision, out_of_bounds;
  logic [FN-1:0] field_display;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  field_merge_seq #(.FIELD_W(FW), .FIELD_H(FH), .BLK(BL), .POS_W(PW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .mode             (mode),
    .pos_x            (pos_x),
    .pos_y            (pos_y),
    .block_matrix     (block_matrix),
    .field_background (field_background),
    .busy             (busy),
    .done             (done),
    .collision        (collision),
    .out_of_bounds    (out_of_bounds),
    .field_display    (field_display)
  );

  task automatic chk(input string tag, input logic [FN-1:0] act, input logic [FN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [FN-1:0] rand_bg(input int pct);
    logic [FN-1:0] v;
    for (int i = 0; i < FN; i++) v[i] = ($urandom_range(99) < pct);
    return v;
  endfunction

  function automatic exp_t model(input logic m, input logic [PW-1:0] px, input logic [PW-1:0] py,
                                 input logic [BL*BL-1:0] bm, input logic [FN-1:0] bg);
    exp_t e;
    logic [FN-1:0] w;
    w = bg;
    e.coll = 1'b0;
    e.oob  = 1'b0;
    for (int by = 0; by < BL; by++)
      for (int bx = 0; bx < BL; bx++)
        if (bm[by*BL+bx]) begin
          int x;
          int y;
          x = int'(px) + bx;
          y = int'(py) + by;
          if (x >= FW || y >= FH) e.oob = 1'b1;
          else begin
            if (bg[cell_idx(x, y, FW)]) e.coll = 1'b1;
            w[cell_idx(x, y, FW)] = 1'b1;
          end
        end
    e.disp = (m && (e.coll || e.oob)) ? bg : w;
    return e;
  endfunction

  task automatic scramble();
    mode         = 1'($urandom);
    pos_x        = PW'($urandom);
    pos_y        = PW'($urandom);
    block_matrix = (BL*BL)'($urandom);
    field_background = rand_bg(50);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, FN'(busy), FN'(0));
    chk({tag, "_done"}, FN'(done), FN'(0));
    chk({tag, "_coll"}, FN'(collision), FN'(0));
    chk({tag, "_oob"},  FN'(out_of_bounds), FN'(0));
    chk({tag, "_disp"}, field_display, '0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      chk("q_nonempty", FN'(q.size() > 0), FN'(1));
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("disp", field_display, mon_e.disp);
        chk("coll", FN'(collision), FN'(mon_e.coll));
        chk("oob",  FN'(out_of_bounds), FN'(mon_e.oob));
      end
    end
  end

  // poke: cycle after start at which a stray start pulse is injected (-1 = none)
  task automatic run_op(input logic m, input logic [PW-1:0] px, input logic [PW-1:0] py,
                        input logic [BL*BL-1:0] bm, input logic [FN-1:0] bg, input int poke);
    exp_t e;
    int n;
    int d0;
    @(negedge clk);
    mode = m; pos_x = px; pos_y = py; block_matrix = bm; field_background = bg;
    start = 1'b1;
    e = model(m, px, py, bm, bg);
    q.push_back(e);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    chk("busy_start", FN'(busy), FN'(1));
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      start = (n == poke);
    end
    start = 1'b0;
    chk("latency", FN'(n), FN'(BL*BL+1));
    chk("busy_done", FN'(busy), FN'(1));
    repeat (20) @(posedge clk);
    #1;
    chk("one_done",  FN'(done_cnt - d0), FN'(1));
    chk("busy_idle", FN'(busy), FN'(0));
    chk("coll_held", FN'(collision), FN'(e.coll));
    chk("oob_held",  FN'(out_of_bounds), FN'(e.oob));
    chk("disp_held", field_display, e.disp);
  endtask

  task automatic back2back();
    int n;
    @(negedge clk);
    mode = 1'b0; pos_x = 5'd2; pos_y = 5'd2; block_matrix = 16'h0660;
    field_background = rand_bg(20);
    start = 1'b1;
    q.push_back(model(mode, pos_x, pos_y, block_matrix, field_background));
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_lat_a", FN'(n), FN'(BL*BL+1));
    mode = 1'b1; pos_x = 5'd10; pos_y = 5'd12; block_matrix = 16'h0F00;
    field_background = rand_bg(10);
    q.push_back(model(mode, pos_x, pos_y, block_matrix, field_background));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("b2b_busy", FN'(busy), FN'(1));
      start = 1'b0;
    end while (!done && n < 40);
    chk("b2b_lat_b", FN'(n), FN'(BL*BL+2));
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_busy_idle", FN'(busy), FN'(0));
  endtask

  task automatic reset_mid_scan();
    int d0;
    @(negedge clk);
    mode = 1'b1; pos_x = '0; pos_y = '0; block_matrix = '1;
    field_background = '1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("scan_coll_sticky", FN'(collision), FN'(1));
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_no_done", FN'(done_cnt - d0), FN'(0));
    chk_zero("rst_after");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [FN-1:0] k;
    logic [FN-1:0] bg;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      scramble();
      start = 1'($urandom);
      @(negedge clk);
      chk_zero("reset");
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // overlay on empty field
    run_op(1'b0, 5'd3, 5'd5, 16'h0033, '0, -1);
    k = '0; k[103] = 1'b1; k[104] = 1'b1; k[123] = 1'b1; k[124] = 1'b1;
    chk("ovl_const", field_display, k);

    // lock rejected by collision at cell 104
    bg = '0; bg[104] = 1'b1;
    run_op(1'b1, 5'd3, 5'd5, 16'h0033, bg, -1);
    chk("lock_coll_disp", field_display, bg);

    // right-edge clipping must not wrap into x=0
    run_op(1'b0, 5'd19, 5'd5, 16'h0033, '0, -1);
    k = '0; k[119] = 1'b1; k[139] = 1'b1;
    chk("clip_const", field_display, k);
    chk("clip_oob", FN'(out_of_bounds), FN'(1));

    // widest position, both modes
    bg = rand_bg(30);
    run_op(1'b0, 5'd31, 5'd0, 16'h0001, bg, -1);
    chk("wide_disp", field_display, bg);
    run_op(1'b1, 5'd31, 5'd19, 16'h0001, bg, -1);

    // successful lock, bottom-right corner
    bg = '0; bg[0] = 1'b1; bg[FN-1] = 1'b0; bg[200] = 1'b1;
    run_op(1'b1, 5'd16, 5'd16, 16'hF000, bg, -1);
    k = bg; k[19*FW+16] = 1'b1; k[19*FW+17] = 1'b1; k[19*FW+18] = 1'b1; k[19*FW+19] = 1'b1;
    chk("lock_ok_const", field_display, k);

    // stray start mid-operation
    run_op(1'b0, 5'd7, 5'd7, 16'h8421, rand_bg(15), 5);

    for (int i = 0; i < 6; i++)
      run_op(1'($urandom), PW'($urandom_range(22)), PW'($urandom_range(22)),
             (BL*BL)'($urandom), rand_bg(15), -1);

    back2back();
    reset_mid_scan();

    // recovery after reset
    run_op(1'b0, 5'd0, 5'd0, 16'h0001, '0, -1);
    chk("q_empty", FN'(q.size()), FN'(0));

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
